// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receive path: FSM states, SCON mode codes,
// sample points within a bit period and the majority helper.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_SHIFT0 = 3'd4
  } rx_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam logic [3:0] SAMPLE_A  = 4'd7;
  localparam logic [3:0] SAMPLE_B  = 4'd8;
  localparam logic [3:0] SAMPLE_C  = 4'd9;
  localparam logic [3:0] TICK_WRAP = 4'd15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_rx_input_shifter_reg.sv
// RXD front end: 2-FF synchronizer, registered falling-edge detect, 3-sample
// majority voter and the 9-bit LSB-first receive shift register.
module serial_rx_input_shifter_reg
  import serial_rx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  input  logic       sample7_i,
  input  logic       sample8_i,
  input  logic       shift_maj_i,
  input  logic       shift_raw_i,
  output logic       fall_o,
  output logic       rxd_sync_o,
  output logic       maj_o,
  output logic [8:0] shreg_o
);

  logic       meta_q, sync_q, prev_q;
  logic       s7_q, s8_q;
  logic [8:0] sh_q, sh_d;

  // New bits enter at the MSB so the first received bit ends up lowest.
  always_comb begin
    sh_d = sh_q;
    if (shift_maj_i)      sh_d = {maj_o, sh_q[8:1]};
    else if (shift_raw_i) sh_d = {sync_q, sh_q[8:1]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      s7_q   <= 1'b1;
      s8_q   <= 1'b1;
      sh_q   <= 9'h000;
    end else begin
      meta_q <= rxd_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (sample7_i) s7_q <= sync_q;
      if (sample8_i) s8_q <= sync_q;
      sh_q <= sh_d;
    end
  end

  assign fall_o     = prev_q & ~sync_q;
  assign rxd_sync_o = sync_q;
  assign maj_o      = maj3(s7_q, s8_q, sync_q);
  assign shreg_o    = sh_q;

endmodule

// File: rtl/serial_rx.sv
// 8051 serial receiver: frame FSM for SCON modes 0-3, tick/bit counters and
// the registered SBUF/RB8/RI outputs handed to the SFR block.
module serial_rx
  import serial_rx_pkg::*;
(
  input  logic       serial_clock_i,
  input  logic       serial_reset_i_b,
  input  logic       serial_br_i,
  input  logic       serial_rxd_i,
  input  logic       serial_scon7_sm0_i,
  input  logic       serial_scon6_sm1_i,
  input  logic       serial_scon5_sm2_i,
  input  logic       serial_scon4_ren_i,
  input  logic       serial_scon0_ri_i,
  output logic [7:0] serial_data_sbuf_o,
  output logic       serial_scon2_rb8_o,
  output logic       serial_scon0_ri_o,
  output logic       serial_shift_clk_o,
  output logic       serial_rx_busy_o
);

  rx_state_e  state_q;
  logic [3:0] tick_q, bit_q;
  logic [1:0] mode_q;
  logic       phase_q;
  logic [7:0] sbuf_q;
  logic       rb8_q, ri_q, sclk_q;

  logic [1:0] mode;
  logic       fall, rxd_sync, maj;
  logic [8:0] sh;
  logic       in_uart, at7, at8, at9, at_wrap, abort;
  logic [3:0] last_bit;
  logic       rx_flag;
  logic [7:0] rx_byte;

  assign mode     = {serial_scon7_sm0_i, serial_scon6_sm1_i};
  assign in_uart  = state_q inside {ST_START, ST_DATA, ST_STOP};
  assign at7      = serial_br_i && (tick_q == SAMPLE_A);
  assign at8      = serial_br_i && (tick_q == SAMPLE_B);
  assign at9      = serial_br_i && (tick_q == SAMPLE_C);
  assign at_wrap  = serial_br_i && (tick_q == TICK_WRAP);
  assign abort    = (state_q != ST_IDLE) && (!serial_scon4_ren_i || (mode != mode_q));
  assign last_bit = (mode_q == MODE1) ? 4'd7 : 4'd8;
  // Mode 1 qualifies on the stop bit being sampled now; modes 2/3 on the 9th data bit.
  assign rx_flag  = (mode_q == MODE1) ? maj : sh[8];
  assign rx_byte  = (mode_q == MODE1) ? sh[8:1] : sh[7:0];

  serial_rx_input_shifter_reg u_shifter (
    .clk_i       (serial_clock_i),
    .rst_ni      (serial_reset_i_b),
    .rxd_i       (serial_rxd_i),
    .sample7_i   (in_uart && at7),
    .sample8_i   (in_uart && at8),
    .shift_maj_i ((state_q == ST_DATA) && at9),
    .shift_raw_i ((state_q == ST_SHIFT0) && serial_br_i && phase_q),
    .fall_o      (fall),
    .rxd_sync_o  (rxd_sync),
    .maj_o       (maj),
    .shreg_o     (sh)
  );

  always_ff @(posedge serial_clock_i) begin
    if (!serial_reset_i_b) begin
      state_q <= ST_IDLE;
      tick_q  <= 4'd0;
      bit_q   <= 4'd0;
      mode_q  <= MODE0;
      phase_q <= 1'b0;
      sbuf_q  <= 8'h00;
      rb8_q   <= 1'b0;
      ri_q    <= 1'b0;
      sclk_q  <= 1'b1;
    end else begin
      ri_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        tick_q  <= 4'd0;
        sclk_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            tick_q  <= 4'd0;
            bit_q   <= 4'd0;
            phase_q <= 1'b0;
            sclk_q  <= 1'b1;
            mode_q  <= mode;
            if (serial_scon4_ren_i) begin
              // ri_q guards the cycle before the SFR reflects our own RI set.
              if (mode == MODE0) begin
                if (!serial_scon0_ri_i && !ri_q) state_q <= ST_SHIFT0;
              end else if (fall) begin
                state_q <= ST_START;
              end
            end
          end
          ST_START: begin
            if (serial_br_i) tick_q <= tick_q + 4'd1;
            if (at9 && maj)   state_q <= ST_IDLE;
            else if (at_wrap) state_q <= ST_DATA;
          end
          ST_DATA: begin
            if (serial_br_i) tick_q <= tick_q + 4'd1;
            if (at_wrap) begin
              if (bit_q == last_bit) state_q <= ST_STOP;
              else                   bit_q   <= bit_q + 4'd1;
            end
          end
          ST_STOP: begin
            if (serial_br_i) tick_q <= tick_q + 4'd1;
            if (at9) begin
              state_q <= ST_IDLE;
              if (!serial_scon0_ri_i && (!serial_scon5_sm2_i || rx_flag)) begin
                sbuf_q <= rx_byte;
                rb8_q  <= rx_flag;
                ri_q   <= 1'b1;
              end
            end
          end
          ST_SHIFT0: begin
            if (serial_br_i) begin
              phase_q <= ~phase_q;
              if (!phase_q) begin
                sclk_q <= 1'b0;
              end else begin
                sclk_q <= 1'b1;
                if (bit_q == 4'd7) begin
                  sbuf_q  <= {rxd_sync, sh[8:2]};
                  ri_q    <= 1'b1;
                  state_q <= ST_IDLE;
                end else begin
                  bit_q <= bit_q + 4'd1;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign serial_data_sbuf_o = sbuf_q;
  assign serial_scon2_rb8_o = rb8_q;
  assign serial_scon0_ri_o  = ri_q;
  assign serial_shift_clk_o = sclk_q;
  assign serial_rx_busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: directed frames in all modes, an expected queue of
// {SBUF,RB8} popped by a monitor on each RI pulse, plus direct state checks.
module tb_serial_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       br = 1'b0;
  logic       rxd = 1'b1;
  logic       sm0 = 1'b0, sm1 = 1'b1, sm2 = 1'b0, ren = 1'b0, ri_i = 1'b0;
  logic [7:0] sbuf;
  logic       rb8, ri_o, sclk, busy;

  logic       ri_flag = 1'b0, ri_force = 1'b0, ri_clr = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  int         total = 0;
  int         bad = 0;
  int         br_cnt = 0;
  int         pulses;
  bit         ok;
  logic [7:0] m0_byte;

  serial_rx dut (
    .serial_clock_i     (clk),
    .serial_reset_i_b   (rst_n),
    .serial_br_i        (br),
    .serial_rxd_i       (rxd),
    .serial_scon7_sm0_i (sm0),
    .serial_scon6_sm1_i (sm1),
    .serial_scon5_sm2_i (sm2),
    .serial_scon4_ren_i (ren),
    .serial_scon0_ri_i  (ri_i),
    .serial_data_sbuf_o (sbuf),
    .serial_scon2_rb8_o (rb8),
    .serial_scon0_ri_o  (ri_o),
    .serial_shift_clk_o (sclk),
    .serial_rx_busy_o   (busy)
  );

  // clock / baud tick / SFR RI flag model
  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    br_cnt = (br_cnt + 1) % 4;
    br = (br_cnt == 0);
  end

  initial forever begin
    @(posedge clk); #1;
    if (ri_o)        ri_flag = 1'b1;
    else if (ri_clr) ri_flag = 1'b0;
    ri_i = ri_flag | ri_force;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_uart(input logic [8:0] bits, input int nbits);
    rxd = 1'b0;
    cyc(64);
    for (int i = 0; i < nbits; i++) begin
      rxd = bits[i];
      cyc(64);
    end
    rxd = 1'b1;
    cyc(128);
  endtask

  task automatic clear_ri();
    ri_clr = 1'b1;
    cyc(2);
    ri_clr = 1'b0;
    cyc(1);
  endtask

  task automatic wait_sclk(input logic lvl, output bit got);
    int n;
    n = 0;
    got = 1'b1;
    while (sclk !== lvl) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        got = 1'b0;
        break;
      end
    end
  endtask

  // scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (ri_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ri: got pulse sbuf=%0h rb8=%0b required no pulse", sbuf, rb8);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_sbuf", {24'h0, sbuf}, {24'h0, mon_e[8:1]});
        check("rx_rb8", {31'h0, rb8}, {31'h0, mon_e[0]});
      end
    end
  end

  // stimulus
  initial begin
    cyc(3);
    check("rst_sbuf", {24'h0, sbuf}, 32'h00);
    check("rst_rb8", {31'h0, rb8}, 32'h0);
    check("rst_ri", {31'h0, ri_o}, 32'h0);
    check("rst_sclk", {31'h0, sclk}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    cyc(5);

    // mode 1 frame 0xA5
    sm0 = 1'b0; sm1 = 1'b1; sm2 = 1'b0; ren = 1'b1;
    cyc(10);
    exp_q.push_back({8'hA5, 1'b1});
    fork
      send_uart({1'b0, 8'hA5}, 8);
      begin cyc(100); check("m1_busy", {31'h0, busy}, 32'h1); end
    join
    check("m1_a5_seen", exp_q.size(), 0);

    // mode 3 multiprocessor: bit8=0 rejected, bit8=1 accepted
    clear_ri();
    sm0 = 1'b1; sm1 = 1'b1; sm2 = 1'b1;
    cyc(4);
    send_uart({1'b0, 8'h3C}, 9);
    check("m3_b80_sbuf", {24'h0, sbuf}, 32'hA5);
    check("m3_b80_rb8", {31'h0, rb8}, 32'h1);
    exp_q.push_back({8'h3C, 1'b1});
    send_uart({1'b1, 8'h3C}, 9);
    check("m3_b81_seen", exp_q.size(), 0);

    // mode 1 false start: 16-cycle low glitch
    clear_ri();
    sm0 = 1'b0; sm1 = 1'b1; sm2 = 1'b0;
    cyc(4);
    rxd = 1'b0;
    cyc(10);
    check("fs_busy_on", {31'h0, busy}, 32'h1);
    cyc(6);
    rxd = 1'b1;
    cyc(50);
    check("fs_busy_off", {31'h0, busy}, 32'h0);
    check("fs_sbuf", {24'h0, sbuf}, 32'h3C);

    // mode 2 with RI already set: no load
    clear_ri();
    ri_force = 1'b1;
    sm0 = 1'b1; sm1 = 1'b0;
    cyc(4);
    send_uart({1'b0, 8'h55}, 9);
    check("m2_ri_sbuf", {24'h0, sbuf}, 32'h3C);
    ri_force = 1'b0;
    clear_ri();

    // mode 0 shift of 0x3C
    ren = 1'b0;
    sm0 = 1'b0; sm1 = 1'b0;
    clear_ri();
    m0_byte = 8'h3C;
    exp_q.push_back({8'h3C, 1'b1});
    pulses = 0;
    ren = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_sclk(1'b0, ok);
      if (!ok) begin
        total++; bad++;
        $display("FAIL m0_sclk_fall: got no falling edge for bit %0d required edge", i);
        break;
      end
      rxd = m0_byte[i];
      wait_sclk(1'b1, ok);
      if (!ok) begin
        total++; bad++;
        $display("FAIL m0_sclk_rise: got no rising edge for bit %0d required edge", i);
        break;
      end
      pulses++;
    end
    rxd = 1'b1;
    cyc(20);
    check("m0_pulses", pulses, 8);
    check("m0_sclk_idle", {31'h0, sclk}, 32'h1);
    check("m0_busy", {31'h0, busy}, 32'h0);
    check("m0_seen", exp_q.size(), 0);
    ren = 1'b0;

    // mode 1 reset during data bit 4, then frame 0x81
    clear_ri();
    sm0 = 1'b0; sm1 = 1'b1; sm2 = 1'b0; ren = 1'b1;
    cyc(10);
    fork
      send_uart({1'b0, 8'hF0}, 8);
      begin
        cyc(350);
        check("rst_mid_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        cyc(1);
        check("rst_mid_sbuf", {24'h0, sbuf}, 32'h00);
        check("rst_mid_rb8", {31'h0, rb8}, 32'h0);
        check("rst_mid_ri", {31'h0, ri_o}, 32'h0);
        check("rst_mid_sclk", {31'h0, sclk}, 32'h1);
        check("rst_mid_busy0", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
      end
    join
    cyc(20);
    exp_q.push_back({8'h81, 1'b1});
    send_uart({1'b0, 8'h81}, 8);
    check("m1_81_seen", exp_q.size(), 0);

    cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
# serial_rx

Receive half of the EMC08 serial port: recovers 8051-style serial frames from the RXD pin in all four SCON modes, assembles them, and hands the received byte, RB8 and an RI set request to the SFR block. Pairs with the transmit datapath under the serial top; shares the baud tick from the baud-rate generator.

## Interface
Parameters:
- none; widths fixed by the 8051 SCON/SBUF architecture.

Ports:
- serial_clock_i  in  1  system clock
- serial_reset_i_b  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- serial_br_i  in  1  one-cycle baud tick; 16x bit rate in modes 1-3, one tick per half shift period in mode 0
- serial_rxd_i  in  1  RXD pin, asynchronous
- serial_scon7_sm0_i  in  1  SM0
- serial_scon6_sm1_i  in  1  SM1; mode = {SM0,SM1}
- serial_scon5_sm2_i  in  1  SM2, multiprocessor enable
- serial_scon4_ren_i  in  1  receive enable
- serial_scon0_ri_i  in  1  current RI flag
- serial_data_sbuf_o  out  8  received byte; reset 8'h00; holds until next load
- serial_scon2_rb8_o  out  1  received 9th bit / stop bit; reset 0
- serial_scon0_ri_o  out  1  one-cycle pulse, sets RI; reset 0
- serial_shift_clk_o  out  1  mode 0 shift clock to TXD pin; reset 1
- serial_rx_busy_o  out  1  frame in progress; reset 0

## Operation
- RXD passes a 2-FF synchronizer, then a registered edge detector; falling edge = sync_prev 1, sync 0.
- States: IDLE, START, DATA, STOP (modes 1-3); SHIFT0 (mode 0).
- IDLE: modes 1-3 with REN=1, falling edge -> START, tick counter=0, bit counter=0. Mode 0 with REN=1 and RI=0 -> SHIFT0.
- Tick counter 4 bits, increments on serial_br_i, wraps 15->0; wrap ends a bit period.
- Bit value = majority of samples at tick counts 7, 8, 9.
- START: majority 1 at count 9 -> false start, back to IDLE. Else at wrap -> DATA.
- DATA: LSB first into 9-bit shifter; 8 bits mode 1, 9 bits modes 2/3; last bit wrap -> STOP.
- STOP: at count 9 decide load, return IDLE (no wait for end of stop bit).
  - Mode 1: load if RI=0 and (SM2=0 or stop=1); RB8 = stop bit.
  - Modes 2/3: load if RI=0 and (SM2=0 or bit8=1); RB8 = bit8.
  - Load: SBUF, RB8 updated and RI pulse in same cycle. No load: outputs unchanged, no pulse.
- SHIFT0: 8 bits; per bit, tick A drives shift_clk 0, tick B drives shift_clk 1 and samples RXD (LSB first). After 8th sample: load SBUF, RI pulse, RB8 unchanged, IDLE.
- REN falling or mode change mid-frame: abort to IDLE next cycle, no load, shift_clk 1.
- serial_rx_busy_o = state != IDLE.

## Timing
- Pin fall to START entry: 3 cycles (2 sync + edge register).
- RI pulse: exactly one cycle, same cycle as SBUF/RB8 update, registered outputs.
- Falling edge and serial_br_i in same cycle: tick not counted (counter starts at 0 next cycle).
- New falling edge accepted in the cycle after return to IDLE; back-to-back frames supported.
- Reset asserted mid-frame: all state and outputs to reset values on that edge.

## Structure
- Shared serial defines: state encodings, mode codes (MODE0..MODE3), sample indices 7/8/9, tick wrap 15.
- Sub-module serial_rx_input_shifter_reg: synchronizer, edge detect, majority voter, 9-bit shift register; control FSM and counters in serial_rx.

## Test plan
- Mode 1, SM2=0, RI=0, 16x ticks, frame 0xA5 stop 1 -> SBUF=8'hA5, RB8=1, one RI pulse at STOP count 9.
- Mode 3, SM2=1, frame 0x3C bit8=0 -> no load, no RI; repeat with bit8=1 -> SBUF=8'h3C, RB8=1, RI pulse.
- Mode 1, RXD low pulse for 4 ticks only -> false start, IDLE, no RI, busy deasserts by count 9.
- Mode 2, RI_i=1, frame 0x55 -> SBUF keeps previous value, no RI pulse.
- Mode 0, REN=1, RI=0, RXD driven per shift_clk rising with 0x3C -> 8 shift_clk pulses, SBUF=8'h3C, RI pulse, shift_clk idles 1.
- Mode 1, reset asserted during DATA bit 4 -> all outputs at reset values next cycle; next full frame 0x81 received correctly.
